// File: rtl/card_dealer_if.sv
// Handshake and card bus between the game FSM (master) and the card dealer (slave).
interface card_dealer_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] i_Seed;
    logic             i_LoadSeed;
    logic             i_Draw;
    logic             i_Shuffle;
    logic [3:0]       o_Rank;
    logic [1:0]       o_Suit;
    logic [3:0]       o_Value;
    logic             o_Valid;
    logic             o_Busy;
    logic [5:0]       o_CardsLeft;
    logic             o_DeckEmpty;

    modport master (
        output i_Seed, i_LoadSeed, i_Draw, i_Shuffle,
        input  o_Rank, o_Suit, o_Value, o_Valid, o_Busy, o_CardsLeft, o_DeckEmpty
    );

    modport slave (
        input  i_Seed, i_LoadSeed, i_Draw, i_Shuffle,
        output o_Rank, o_Suit, o_Value, o_Valid, o_Busy, o_CardsLeft, o_DeckEmpty
    );
endinterface

// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck: LFSR picks a start slot,
// then a linear probe walks the dealt mask one bit per cycle to the next free card.
module card_dealer #(
    parameter int unsigned WIDTH     = 12,
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic         clk_50M,
    input  logic         i_Reset,
    card_dealer_if.slave bus
);
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned DECK     = 52;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DEAL  = 2'd2
    } state_t;

    state_t              state;
    logic [DECK-1:0]     dealt_mask;
    logic [LFSR_W-1:0]   lfsr;
    logic [IDX_W-1:0]    idx;

    logic [WIDTH-1:0]    seed_w;
    logic [LFSR_W-1:0]   seed_ext;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    rem;
    logic [3:0]          rank_c;
    logic [1:0]          suit_c;
    logic [3:0]          value_c;

    // Seed widening and LFSR feedback (taps 16,14,13,11)
    always_comb begin
        seed_w    = bus.i_Seed;
        seed_ext  = LFSR_W'(seed_w);
        lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        cand      = lfsr[IDX_W-1:0];
    end

    // Slot index to suit/rank/value using compares and subtracts only
    always_comb begin
        suit_c = 2'd0;
        rem    = idx;
        if (idx >= IDX_W'(39)) begin
            suit_c = 2'd3;
            rem    = idx - IDX_W'(39);
        end else if (idx >= IDX_W'(26)) begin
            suit_c = 2'd2;
            rem    = idx - IDX_W'(26);
        end else if (idx >= IDX_W'(13)) begin
            suit_c = 2'd1;
            rem    = idx - IDX_W'(13);
        end
        rank_c = 4'(rem + IDX_W'(1));
        if (rank_c == 4'd1)
            value_c = 4'd11;
        else if (rank_c >= 4'd10)
            value_c = 4'd10;
        else
            value_c = rank_c;
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state           <= IDLE;
            dealt_mask      <= '0;
            lfsr            <= LFSR_INIT;
            idx             <= '0;
            bus.o_Rank      <= '0;
            bus.o_Suit      <= '0;
            bus.o_Value     <= '0;
            bus.o_Valid     <= 1'b0;
            bus.o_Busy      <= 1'b0;
            bus.o_CardsLeft <= 6'(DECK);
            bus.o_DeckEmpty <= 1'b0;
        end else begin
            // A seed load is independent of the FSM so it never disturbs a draw
            if (bus.i_LoadSeed)
                lfsr <= (seed_ext == '0) ? LFSR_INIT : seed_ext;
            else
                lfsr <= lfsr_step;

            bus.o_Valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_Shuffle) begin
                        dealt_mask      <= '0;
                        bus.o_CardsLeft <= 6'(DECK);
                        bus.o_DeckEmpty <= 1'b0;
                    end else if (bus.i_Draw && !bus.o_DeckEmpty) begin
                        idx        <= (cand >= IDX_W'(DECK)) ? cand - IDX_W'(DECK) : cand;
                        bus.o_Busy <= 1'b1;
                        state      <= PROBE;
                    end
                end
                PROBE: begin
                    if (!dealt_mask[idx]) begin
                        dealt_mask[idx] <= 1'b1;
                        bus.o_CardsLeft <= bus.o_CardsLeft - 6'd1;
                        bus.o_DeckEmpty <= (bus.o_CardsLeft == 6'd1);
                        bus.o_Rank      <= rank_c;
                        bus.o_Suit      <= suit_c;
                        bus.o_Value     <= value_c;
                        bus.o_Valid     <= 1'b1;
                        state           <= DEAL;
                    end else begin
                        idx <= (idx == IDX_W'(DECK - 1)) ? '0 : idx + IDX_W'(1);
                    end
                end
                DEAL: begin
                    bus.o_Busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.o_Busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer against a deck-level reference model.
module tb_card_dealer;
    localparam logic [15:0] INIT = 16'hACE1;

    logic clk_50M = 1'b0;
    logic i_Reset = 1'b0;

    card_dealer_if #(.WIDTH(12)) bus ();

    card_dealer #(.WIDTH(12), .LFSR_INIT(INIT)) u_dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] m_lfsr;
    bit   dealt [52];
    int   m_cards;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return {l[14:0], 1'(fb)};
    endfunction

    // Reference LFSR tracks the generator cycle by cycle from the primary inputs
    always @(posedge clk_50M) begin
        if (i_Reset)
            m_lfsr <= INIT;
        else if (bus.i_LoadSeed)
            m_lfsr <= (bus.i_Seed == 12'h000) ? INIT : 16'(bus.i_Seed);
        else
            m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 52; i++) dealt[i] = 1'b0;
        m_cards = 52;
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        model_clear();
    endtask

    task automatic load(input logic [11:0] seed);
        bus.i_Seed     = seed;
        bus.i_LoadSeed = 1'b1;
        tick();
        bus.i_LoadSeed = 1'b0;
    endtask

    // One draw; poke=1 also fires draw/shuffle/load while the dealer is busy
    task automatic draw(input string tag, input bit poke, output int lat);
        int c, idx, k, n, bad, er, es, ev;
        lat = 0;
        if (m_cards == 0) begin
            bus.i_Draw = 1'b1;
            tick();
            bus.i_Draw = 1'b0;
            bad = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus.o_Valid || bus.o_Busy) bad++;
                tick();
            end
            check({tag, "_empty_quiet"}, bad, 0);
            check({tag, "_empty_left"}, int'(bus.o_CardsLeft), 0);
            return;
        end
        c   = int'(m_lfsr[5:0]);
        idx = (c >= 52) ? c - 52 : c;
        k   = 0;
        while (dealt[idx]) begin
            idx = (idx + 1) % 52;
            k++;
        end
        dealt[idx] = 1'b1;
        m_cards--;
        er = idx % 13 + 1;
        es = idx / 13;
        ev = (er == 1) ? 11 : (er >= 10) ? 10 : er;

        bus.i_Draw = 1'b1;
        tick();
        bus.i_Draw = 1'b0;
        n = 1;
        while (!bus.o_Valid && n < 60) begin
            if (poke && n == 1) begin
                check({tag, "_busy"}, int'(bus.o_Busy), 1);
                bus.i_Draw     = 1'b1;
                bus.i_Shuffle  = 1'b1;
                bus.i_Seed     = 12'($urandom_range(1, 4095));
                bus.i_LoadSeed = 1'b1;
            end
            tick();
            bus.i_Draw     = 1'b0;
            bus.i_Shuffle  = 1'b0;
            bus.i_LoadSeed = 1'b0;
            n++;
        end
        lat = n;
        check({tag, "_lat"},   n, 2 + k);
        check({tag, "_rank"},  int'(bus.o_Rank), er);
        check({tag, "_suit"},  int'(bus.o_Suit), es);
        check({tag, "_value"}, int'(bus.o_Value), ev);
        check({tag, "_left"},  int'(bus.o_CardsLeft), m_cards);
        check({tag, "_empty"}, int'(bus.o_DeckEmpty), int'(m_cards == 0));
        tick();
        check({tag, "_valid_pulse"}, int'(bus.o_Valid), 0);
    endtask

    int lat;
    int seen [52];
    int dup, bad;

    initial begin
        bus.i_Seed = '0; bus.i_LoadSeed = 0; bus.i_Draw = 0; bus.i_Shuffle = 0;
        tick();
        do_reset();
        check("rst_rank",  int'(bus.o_Rank), 0);
        check("rst_suit",  int'(bus.o_Suit), 0);
        check("rst_value", int'(bus.o_Value), 0);
        check("rst_valid", int'(bus.o_Valid), 0);
        check("rst_busy",  int'(bus.o_Busy), 0);
        check("rst_empty", int'(bus.o_DeckEmpty), 0);
        check("rst_left",  int'(bus.o_CardsLeft), 52);

        // Seed 0x033 -> slot 51 (king of suit 3)
        load(12'h033);
        draw("t1", 0, lat);
        check("t1_lat_c", lat, 2);
        check("t1_rank_c", int'(bus.o_Rank), 13);
        check("t1_suit_c", int'(bus.o_Suit), 3);
        check("t1_left_c", int'(bus.o_CardsLeft), 51);

        // Reload same seed: slot 51 taken, probe wraps to 0
        load(12'h033);
        draw("t3", 0, lat);
        check("t3_lat_c", lat, 3);
        check("t3_rank_c", int'(bus.o_Rank), 1);
        check("t3_suit_c", int'(bus.o_Suit), 0);

        // Seed 0x034 = 52 folds to slot 0
        do_reset();
        load(12'h034);
        draw("t2", 0, lat);
        check("t2_lat_c", lat, 2);
        check("t2_rank_c", int'(bus.o_Rank), 1);
        check("t2_value_c", int'(bus.o_Value), 11);

        // Zero seed falls back to the init value: ACE1 -> slot 33
        do_reset();
        load(12'h000);
        draw("t6z", 0, lat);
        check("t6z_rank_c", int'(bus.o_Rank), 8);
        check("t6z_suit_c", int'(bus.o_Suit), 2);

        // Occupy slots 0..4, start a long probe from slot 0, reset mid-probe
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load(12'(52 + i));
            draw("t6f", 0, lat);
        end
        load(12'h034);
        bus.i_Draw = 1'b1;
        tick();
        bus.i_Draw = 1'b0;
        tick();
        check("t6_mid_busy", int'(bus.o_Busy), 1);
        do_reset();
        check("t6_rst_busy",  int'(bus.o_Busy), 0);
        check("t6_rst_valid", int'(bus.o_Valid), 0);
        check("t6_rst_left",  int'(bus.o_CardsLeft), 52);
        draw("t6r", 0, lat);
        check("t6r_rank_c", int'(bus.o_Rank), 8);
        check("t6r_suit_c", int'(bus.o_Suit), 2);

        // Deal the full deck with random seeds and gaps
        do_reset();
        for (int i = 0; i < 52; i++) seen[i] = 0;
        for (int i = 0; i < 52; i++) begin
            if ($urandom_range(0, 1) == 1) load(12'($urandom_range(0, 4095)));
            repeat ($urandom_range(0, 3)) tick();
            draw("t4", 0, lat);
            seen[int'(bus.o_Suit) * 13 + int'(bus.o_Rank) - 1]++;
        end
        dup = 0;
        for (int i = 0; i < 52; i++) if (seen[i] != 1) dup++;
        check("t4_unique", dup, 0);
        check("t4_empty", int'(bus.o_DeckEmpty), 1);
        draw("t4_53", 0, lat);

        // Shuffle, deal 42, then simultaneous shuffle+draw
        bus.i_Shuffle = 1'b1;
        tick();
        bus.i_Shuffle = 1'b0;
        model_clear();
        check("t5_shuf_left", int'(bus.o_CardsLeft), 52);
        check("t5_shuf_empty", int'(bus.o_DeckEmpty), 0);
        for (int i = 0; i < 42; i++) begin
            if ($urandom_range(0, 3) == 0) load(12'($urandom_range(0, 4095)));
            draw("t5d", 0, lat);
        end
        check("t5_ten", int'(bus.o_CardsLeft), 10);
        bus.i_Shuffle = 1'b1;
        bus.i_Draw    = 1'b1;
        tick();
        bus.i_Shuffle = 1'b0;
        bus.i_Draw    = 1'b0;
        model_clear();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_Valid || bus.o_Busy) bad++;
            tick();
        end
        check("t5_both_quiet", bad, 0);
        check("t5_both_left", int'(bus.o_CardsLeft), 52);

        // Inputs while busy are dropped, not queued
        for (int i = 0; i < 3; i++) begin
            draw("t5p", 1, lat);
            bad = 0;
            for (int j = 0; j < 5; j++) begin
                if (bus.o_Valid || bus.o_Busy) bad++;
                tick();
            end
            check("t5p_no_queue", bad, 0);
        end
        check("t5p_left", int'(bus.o_CardsLeft), 49);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
